seg7_mux_driver: RTL and testbench

SEG7_MUX_DRIVER -- requirements
Module: seg7_mux_driver

---
 rtl/seg7_mux_driver_if.sv | 28 ++
 rtl/seg7_mux_driver.sv | 189 ++++++++++++++++++
 tb/tb_seg7_mux_driver.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/seg7_mux_driver_if.sv
// Host-side bus of the multiplexed seven-segment driver.
//   master : drives load/num/hex_mode/blank_lz, observes busy and the display pins
//   slave  : the driver itself
// Signals:
//   load      capture request, honoured only while busy=0
//   num       unsigned value to show (IN_WIDTH bits)
//   hex_mode  1 = hex nibbles, 0 = decimal (sampled with load)
//   blank_lz  live leading-zero blanking enable
//   busy      conversion in flight
//   Anode     active-low digit enables, bit i = digit i (0 = least significant)
//   LED_out   active-low segments, bit 6 = a .. bit 0 = g
interface seg7_mux_driver_if #(
  parameter int NUM_DIGITS = 8,
  parameter int IN_WIDTH   = 27
);
  logic                  load;
  logic [IN_WIDTH-1:0]   num;
  logic                  hex_mode;
  logic                  blank_lz;
  logic                  busy;
  logic [NUM_DIGITS-1:0] Anode;
  logic [6:0]            LED_out;

  modport master (output load, num, hex_mode, blank_lz,
                  input  busy, Anode, LED_out);
  modport slave  (input  load, num, hex_mode, blank_lz,
                  output busy, Anode, LED_out);
endinterface

// File: rtl/seg7_mux_driver.sv
// Multiplexed seven-segment driver with a sequential binary-to-BCD converter.
// A load in IDLE captures num/hex_mode; decimal values are converted one bit
// per cycle (shift-add-3), hex values are taken as nibbles directly. The
// display register only changes in COMMIT, so partial results never show.
// A free-running prescaler steps the active digit.
// Ports:
//   clk    single clock
//   rst_n  asynchronous active-low reset
//   bus    seg7_mux_driver_if slave modport (load/num/hex_mode/blank_lz in,
//          busy/Anode/LED_out out)

// Per-digit glyph decode with blanking and the overflow dash.
module seg7_lane (
  input  logic [3:0] code_i,
  input  logic       dash_i,
  input  logic       blank_i,
  output logic [6:0] glyph_o
);
  always_comb begin
    glyph_o = 7'b1111111;
    if (dash_i)       glyph_o = 7'b1111110;
    else if (blank_i) glyph_o = 7'b1111111;
    else begin
      unique case (code_i)
        4'h0: glyph_o = 7'b0000001;
        4'h1: glyph_o = 7'b1001111;
        4'h2: glyph_o = 7'b0010010;
        4'h3: glyph_o = 7'b0000110;
        4'h4: glyph_o = 7'b1001100;
        4'h5: glyph_o = 7'b0100100;
        4'h6: glyph_o = 7'b0100000;
        4'h7: glyph_o = 7'b0001111;
        4'h8: glyph_o = 7'b0000000;
        4'h9: glyph_o = 7'b0000100;
        4'hA: glyph_o = 7'b0001000;
        4'hB: glyph_o = 7'b1100000;
        4'hC: glyph_o = 7'b0110001;
        4'hD: glyph_o = 7'b1000010;
        4'hE: glyph_o = 7'b0110000;
        4'hF: glyph_o = 7'b0111000;
        default: glyph_o = 7'b1111111;
      endcase
    end
  end
endmodule

module seg7_mux_driver #(
  parameter int NUM_DIGITS   = 8,
  parameter int IN_WIDTH     = 27,
  parameter int REFRESH_BITS = 18
) (
  input  logic clk,
  input  logic rst_n,
  seg7_mux_driver_if.slave bus
);
  localparam int DW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(IN_WIDTH + 1);
  localparam int IW = $clog2(NUM_DIGITS);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int k = 0; k < n; k++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] OVF_LIM = pow10(NUM_DIGITS);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_t;

  state_t                     state_q, state_d;
  logic [IN_WIDTH-1:0]        sh_q;
  logic [DW-1:0]              bcd_q, bcd_adj;
  logic [CW-1:0]              cnt_q;
  logic                       hex_q, ovf_q;
  logic [NUM_DIGITS-1:0][3:0] disp_q;
  logic                       dash_q;
  logic [REFRESH_BITS-1:0]    presc_q;
  logic [IW-1:0]              idx_q;
  logic [DW-1:0]              hex_digits;
  logic                       accept;

  assign accept = (state_q == S_IDLE) && bus.load;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Hex still passes through SHIFT for one cycle (without shifting) so that
  // both modes share the same commit path; that gives the 2-cycle busy.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (bus.load) state_d = S_SHIFT;
      S_SHIFT:  if (hex_q || cnt_q == CW'(IN_WIDTH - 1)) state_d = S_COMMIT;
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q != S_IDLE);
  end

  // ---------------- datapath ----------------
  // Add-3 on every BCD digit >= 5 before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
  end

  // Hex nibbles: bits beyond IN_WIDTH read as zero.
  for (genvar b = 0; b < DW; b++) begin : g_hex
    if (b < IN_WIDTH) begin : g_in
      assign hex_digits[b] = sh_q[b];
    end else begin : g_zero
      assign hex_digits[b] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q   <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      hex_q  <= 1'b0;
      ovf_q  <= 1'b0;
      disp_q <= '0;
      dash_q <= 1'b0;
    end else begin
      if (accept) begin
        sh_q  <= bus.num;
        hex_q <= bus.hex_mode;
        // Overflow is decided on the raw value; the truncated BCD is discarded.
        ovf_q <= !bus.hex_mode && (64'(bus.num) >= OVF_LIM);
        bcd_q <= '0;
        cnt_q <= '0;
      end else if (state_q == S_SHIFT && !hex_q) begin
        bcd_q <= {bcd_adj[DW-2:0], sh_q[IN_WIDTH-1]};
        sh_q  <= sh_q << 1;
        cnt_q <= cnt_q + CW'(1);
      end else if (state_q == S_COMMIT) begin
        disp_q <= hex_q ? hex_digits : bcd_q;
        dash_q <= ovf_q;
      end
    end
  end

  // ---------------- refresh scan ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else begin
      presc_q <= presc_q + REFRESH_BITS'(1);
      if (&presc_q)
        idx_q <= (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end
  end

  // ---------------- per-digit decode ----------------
  // upper_zero[i]: digit i and everything above it are zero.
  logic [NUM_DIGITS:0]        upper_zero;
  logic [NUM_DIGITS-1:0][6:0] glyph;

  assign upper_zero[NUM_DIGITS] = 1'b1;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_lane
    logic blank;
    assign upper_zero[i] = upper_zero[i+1] && (disp_q[i] == 4'd0);
    if (i == 0) begin : g_lsd
      assign blank = 1'b0;
    end else begin : g_upper
      assign blank = bus.blank_lz && upper_zero[i];
    end
    seg7_lane u_lane (
      .code_i  (disp_q[i]),
      .dash_i  (dash_q),
      .blank_i (blank),
      .glyph_o (glyph[i])
    );
  end

  assign bus.Anode   = ~(NUM_DIGITS'(1) << idx_q);
  assign bus.LED_out = glyph[idx_q];
endmodule

// File: tb/tb_seg7_mux_driver.sv
module tb_seg7_mux_driver;
  localparam int ND = 4, IW = 14, RB = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  seg7_mux_driver_if #(.NUM_DIGITS(ND), .IN_WIDTH(IW)) bus();

  seg7_mux_driver #(.NUM_DIGITS(ND), .IN_WIDTH(IW), .REFRESH_BITS(RB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0]     num;
    logic            hex;
    logic            blz;
    int              busy_cyc;
    logic [3:0][6:0] g;   // expected glyphs, [3] = digit 3
  } vec_t;

  localparam logic [6:0] G0 = 7'b0000001, G9 = 7'b0000100, GB = 7'b1111111,
                         GD = 7'b1111110;

  int total = 0, passed = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d (%b) wanted %0d (%b)", name, act, act, exp, exp);
  endtask

  function automatic int anode_idx(input logic [3:0] a);
    for (int k = 0; k < 4; k++) if (a[k] == 1'b0) return k;
    return 0;
  endfunction

  function automatic int zero_cnt(input logic [3:0] a);
    int c = 0;
    for (int k = 0; k < 4; k++) if (a[k] == 1'b0) c++;
    return c;
  endfunction

  task automatic do_load(input logic [13:0] n, input logic h);
    @(negedge clk);
    bus.num = n; bus.hex_mode = h; bus.load = 1'b1;
    @(posedge clk); #1;
    bus.load = 1'b0;
  endtask

  // Counts busy cycles; while busy, the old display must stay on the pins.
  task automatic wait_busy(input logic [3:0][6:0] hold_g, output int n, output int herr);
    n = 0; herr = 0;
    while (bus.busy && n < 100) begin
      if (bus.LED_out !== hold_g[anode_idx(bus.Anode)]) herr++;
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic sweep(input string nm, input logic [3:0][6:0] g);
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      chk({nm, "_onehot"}, zero_cnt(bus.Anode), 1);
      chk(nm, bus.LED_out, g[anode_idx(bus.Anode)]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[8];
    logic [3:0][6:0] prev_g;
    int n, herr;

    vecs[0] = '{14'd1234,   1'b0, 1'b0, 15, {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}};
    vecs[1] = '{14'd10000,  1'b0, 1'b1, 15, {GD, GD, GD, GD}};
    vecs[2] = '{14'h02AF,   1'b1, 1'b1, 2,  {GB, 7'b0010010, 7'b0001000, 7'b0111000}};
    vecs[3] = '{14'd9999,   1'b0, 1'b0, 15, {G9, G9, G9, G9}};
    vecs[4] = '{14'h3FFF,   1'b1, 1'b0, 2,  {7'b0000110, 7'b0111000, 7'b0111000, 7'b0111000}};
    vecs[5] = '{14'd205,    1'b0, 1'b1, 15, {GB, 7'b0010010, G0, 7'b0100100}};
    vecs[6] = '{14'h000B,   1'b1, 1'b1, 2,  {GB, GB, GB, 7'b1100000}};
    vecs[7] = '{14'd0,      1'b0, 1'b1, 15, {GB, GB, GB, G0}};

    bus.load = 1'b0; bus.num = '0; bus.hex_mode = 1'b0; bus.blank_lz = 1'b0;

    // Reset state before any clock edge.
    #3;
    chk("rst_anode", bus.Anode, 4'b1110);
    chk("rst_led", bus.LED_out, G0);
    chk("rst_busy", bus.busy, 0);

    // Scan cadence: 4 cycles per digit, wrapping 3 -> 0.
    @(negedge clk); rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      chk("scan_idx", anode_idx(bus.Anode), (k / 4) % 4);
    end

    prev_g = {G0, G0, G0, G0};
    for (int i = 0; i < 8; i++) begin
      do_load(vecs[i].num, vecs[i].hex);
      wait_busy(prev_g, n, herr);
      chk("busy_cycles", n, vecs[i].busy_cyc);
      chk("hold_during_busy", herr, 0);
      bus.blank_lz = vecs[i].blz;
      sweep("digits", vecs[i].g);
      prev_g = vecs[i].g;
    end

    // Blanking is live: value 0 shows all zeros as soon as blank_lz drops.
    bus.blank_lz = 1'b0;
    #1;
    chk("blz_toggle_now", bus.LED_out, G0);
    sweep("blz_off", {G0, G0, G0, G0});

    // Loads at E3 and in the COMMIT cycle (E15) must be dropped.
    do_load(14'd99, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk); bus.num = 14'd5; bus.load = 1'b1;
    @(posedge clk); #1; bus.load = 1'b0;
    chk("busy_mid", bus.busy, 1);
    repeat (11) @(posedge clk);
    @(negedge clk); bus.num = 14'd5; bus.load = 1'b1;
    @(posedge clk); #1; bus.load = 1'b0;
    chk("busy_drop_e15", bus.busy, 0);
    @(posedge clk); #1;
    chk("no_queue", bus.busy, 0);
    sweep("show99", {G0, G0, G9, G9});

    // Reset in the middle of a conversion.
    do_load(14'd1234, 1'b0);
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_anode", bus.Anode, 4'b1110);
    chk("mid_rst_led", bus.LED_out, G0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("post_rst_busy", bus.busy, 0);
    sweep("post_rst", {G0, G0, G0, G0});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
